// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and priority helper for the 8-to-3 event encoder.
package encoder_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;

  // Highest set index wins; all-zero input maps to 0.
  function automatic logic [CODE_W-1:0] prio8(input logic [N_LINES-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_LINES); i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/event_encoder8_3_sync_bus.sv
// Multi-bit flop-chain synchronizer; each bit is an independent async level.
module sync_bus #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stages[DEPTH-1];

endmodule

// File: rtl/event_encoder8_3.sv
// Edge-captured request lines, latched as pending events and delivered one at a time
// as a binary code over valid/ready, highest index first.
module event_encoder8_3
  import encoder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E,
  input  logic [N_LINES-1:0]  w,
  output logic [CODE_W-1:0]   y,
  output logic                valid,
  input  logic                ready,
  output logic                drop
);

  logic [N_LINES-1:0] w_ws;
  logic [N_LINES-1:0] w_rise;
  logic [N_LINES-1:0] w_set;
  logic [N_LINES-1:0] w_clr;
  logic [N_LINES-1:0] w_pend_d;
  logic [CODE_W-1:0]  w_sel;
  logic               w_load;
  logic               w_drop_d;

  logic [N_LINES-1:0] r_prev;
  logic [N_LINES-1:0] r_pend;
  logic [CODE_W-1:0]  r_y;
  logic               r_drop;
  state_e             r_state;
  state_e             w_state_d;

  sync_bus #(
    .WIDTH (N_LINES),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w),
    .o_q   (w_ws)
  );

  assign w_rise = w_ws & ~r_prev;
  assign w_set  = w_rise & {N_LINES{~E}};
  assign w_sel  = prio8(r_pend);

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend != '0) begin
          w_load    = 1'b1;
          w_state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ready) begin
          if (r_pend != '0) begin
            w_load = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // A set landing on the index being cleared keeps it pending and is not a drop.
  assign w_clr    = w_load ? (N_LINES'(1) << w_sel) : '0;
  assign w_pend_d = (r_pend & ~w_clr) | w_set;
  assign w_drop_d = |(w_set & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= '0;
      r_pend  <= '0;
      r_y     <= '0;
      r_drop  <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_prev  <= w_ws;
      r_pend  <= w_pend_d;
      r_drop  <= w_drop_d;
      r_state <= w_state_d;
      if (w_load) r_y <= w_sel;
    end
  end

  assign y     = r_y;
  assign valid = (r_state == PRESENT);
  assign drop  = r_drop;

endmodule

// File: tb/tb_event_encoder8_3.sv
// Directed bench for event_encoder8_3: reset, latency, priority, drop, enable gating
// and the simultaneous set/clear case.
module tb_event_encoder8_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       E;
  logic [7:0] w;
  logic [2:0] y;
  logic       valid;
  logic       ready;
  logic       drop;

  int         n_checks = 0;
  int         n_err    = 0;
  int         drop_cnt = 0;
  int         d0;
  logic [2:0] q[$];

  event_encoder8_3 #(
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .w     (w),
    .y     (y),
    .valid (valid),
    .ready (ready),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  // Inputs only move at posedge+2, so the negedge sees stable values for the next edge.
  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (rst_n && valid && ready) q.push_back(y);
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    E     = 1'b0;
    w     = 8'h00;
    ready = 1'b0;
    #1;
    chk("reset_valid", {7'd0, valid}, 8'd0);
    chk("reset_y", {5'd0, y}, 8'd0);
    chk("reset_drop", {7'd0, drop}, 8'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Reset while presenting y=5.
    w = 8'h20;
    cyc(4);
    chk("pre_rst_valid", {7'd0, valid}, 8'd1);
    chk("pre_rst_y", {5'd0, y}, 8'd5);
    w = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {7'd0, valid}, 8'd0);
    chk("midrst_y", {5'd0, y}, 8'd0);
    chk("midrst_drop", {7'd0, drop}, 8'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    chk("post_rst_idle", {7'd0, valid}, 8'd0);
    chk("post_rst_none", 8'(q.size()), 8'd0);

    // Single event, 3-cycle latency, one cycle of valid.
    ready = 1'b1;
    w = 8'h08;
    cyc(3);
    chk("single_early", {7'd0, valid}, 8'd0);
    cyc(1);
    chk("single_valid", {7'd0, valid}, 8'd1);
    chk("single_y", {5'd0, y}, 8'd3);
    cyc(1);
    chk("single_done", {7'd0, valid}, 8'd0);
    w = 8'h00;
    cyc(3);
    chk("single_count", 8'(q.size()), 8'd1);

    // Priority order with back-to-back delivery.
    ready = 1'b0;
    w = 8'h52;
    cyc(4);
    chk("prio_first_valid", {7'd0, valid}, 8'd1);
    chk("prio_first_y", {5'd0, y}, 8'd6);
    w = 8'h00;
    cyc(3);
    chk("prio_hold_y", {5'd0, y}, 8'd6);
    ready = 1'b1;
    cyc(1);
    chk("prio_second_valid", {7'd0, valid}, 8'd1);
    chk("prio_second_y", {5'd0, y}, 8'd4);
    cyc(1);
    chk("prio_third_valid", {7'd0, valid}, 8'd1);
    chk("prio_third_y", {5'd0, y}, 8'd1);
    cyc(1);
    chk("prio_end", {7'd0, valid}, 8'd0);

    // Drop: y=0 held, w[2] pulsed twice while pend[2] is still waiting.
    ready = 1'b0;
    w = 8'h01;
    cyc(3);
    w = 8'h00;
    cyc(3);
    chk("drop_block_y", {5'd0, y}, 8'd0);
    chk("drop_block_valid", {7'd0, valid}, 8'd1);
    d0 = drop_cnt;
    w = 8'h04;
    cyc(3);
    w = 8'h00;
    cyc(3);
    chk("drop_none_yet", 8'(drop_cnt - d0), 8'd0);
    w = 8'h04;
    cyc(3);
    w = 8'h00;
    cyc(4);
    chk("drop_pulses", 8'(drop_cnt - d0), 8'd1);
    q.delete();
    ready = 1'b1;
    cyc(4);
    chk("drop_deliv_n", 8'(q.size()), 8'd2);
    chk("drop_deliv_0", {5'd0, q[0]}, 8'd0);
    chk("drop_deliv_1", {5'd0, q[1]}, 8'd2);
    chk("drop_idle", {7'd0, valid}, 8'd0);

    // Enable gating.
    q.delete();
    d0 = drop_cnt;
    E = 1'b1;
    w = 8'h80;
    cyc(3);
    w = 8'h00;
    cyc(6);
    chk("gate_no_valid", {7'd0, valid}, 8'd0);
    chk("gate_no_event", 8'(q.size()), 8'd0);
    chk("gate_no_drop", 8'(drop_cnt - d0), 8'd0);
    E = 1'b0;
    w = 8'h80;
    cyc(4);
    chk("gate_valid", {7'd0, valid}, 8'd1);
    chk("gate_y", {5'd0, y}, 8'd7);
    cyc(1);
    chk("gate_done", {7'd0, valid}, 8'd0);
    w = 8'h00;
    cyc(3);
    chk("gate_count", 8'(q.size()), 8'd1);

    // Set wins: second w[5] edge lands in the cycle pend[5] is loaded into y.
    ready = 1'b0;
    w = 8'h01;
    cyc(3);
    w = 8'h00;
    cyc(3);
    w = 8'h20;
    cyc(3);
    w = 8'h00;
    cyc(3);
    chk("race_block_y", {5'd0, y}, 8'd0);
    d0 = drop_cnt;
    q.delete();
    w = 8'h20;
    cyc(2);
    ready = 1'b1;
    cyc(4);
    w = 8'h00;
    cyc(3);
    chk("race_n", 8'(q.size()), 8'd3);
    chk("race_0", {5'd0, q[0]}, 8'd0);
    chk("race_1", {5'd0, q[1]}, 8'd5);
    chk("race_2", {5'd0, q[2]}, 8'd5);
    chk("race_no_drop", 8'(drop_cnt - d0), 8'd0);
    chk("race_idle", {7'd0, valid}, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
